// File: rtl/ultrasonic_sensor_emulator_pkg.sv
// Shared types and scaling helpers for the HC-SR04 emulator; the cycles_per_cm
// derivation lives here so the measurement controller can scale identically.
package ultrasonic_sensor_emulator_pkg;

  typedef enum logic [1:0] {IDLE, TRIG_HI, BURST, ECHO} state_e;

  function automatic int unsigned us_to_cycles(input int unsigned us, input int unsigned clk_hz);
    return us * (clk_hz / 1000000);
  endfunction

  // Round-trip time per cm: 2 / speed_of_sound seconds per metre, /100 for cm.
  function automatic int unsigned cycles_per_cm(input int unsigned clk_hz, input int unsigned sos);
    return clk_hz * 2 / sos / 100;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ultrasonic_sensor_emulator_if.sv
// Trig/echo bus between a distance-measurement controller (master) and the sensor (slave).
interface ultrasonic_sensor_emulator_if #(parameter int unsigned DW = 9);
  logic          trig;
  logic [DW-1:0] distance;
  logic          echo;
  logic          busy;

  modport master (output trig, output distance, input echo, input busy);
  modport slave  (input trig, input distance, output echo, output busy);
endinterface

// File: rtl/ultrasonic_sensor_emulator_sync_edge_detect.sv
// Two-flop synchronizer with a registered previous value for rise/fall detection.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);
  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;
endmodule

// File: rtl/ultrasonic_sensor_emulator.sv
// HC-SR04 responder: qualifies trig, waits the burst time, then answers with an
// echo pulse whose width encodes the programmed distance.
module ultrasonic_sensor_emulator
  import ultrasonic_sensor_emulator_pkg::*;
#(
  parameter int unsigned clk_frequency                    = 50000000,
  parameter int unsigned speed_of_sound_meters_per_second = 343,
  parameter int unsigned trig_min_time_in_microseconds    = 10,
  parameter int unsigned burst_time_in_microseconds       = 200,
  parameter int unsigned max_range_in_centimeters         = 400,
  parameter int unsigned no_obstacle_echo_in_microseconds = 38000,
  parameter int unsigned distance_width                   = 9
) (
  input logic                          clk,
  input logic                          reset,
  ultrasonic_sensor_emulator_if.slave  bus
);
  localparam int unsigned TRIG_MIN = us_to_cycles(trig_min_time_in_microseconds, clk_frequency);
  localparam int unsigned BURST_T  = us_to_cycles(burst_time_in_microseconds, clk_frequency);
  localparam int unsigned NO_OBS   = us_to_cycles(no_obstacle_echo_in_microseconds, clk_frequency);
  localparam int unsigned CPC      = cycles_per_cm(clk_frequency, speed_of_sound_meters_per_second);
  localparam int unsigned MAX_ECHO = max_range_in_centimeters * CPC;
  localparam int unsigned LARGEST  = max2(max2(TRIG_MIN, BURST_T), max2(NO_OBS, MAX_ECHO));
  localparam int unsigned CW       = $clog2(LARGEST) + 1;

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [distance_width-1:0] dist_q, dist_d;
  logic                      echo_q, echo_d;
  logic                      trig_sync, trig_rise, trig_fall;
  logic [distance_width+31:0] prod;
  logic [CW-1:0]             echo_len;

  sync_edge_detect u_sync (
    .clk    (clk),
    .reset  (reset),
    .async_i(bus.trig),
    .sync_o (trig_sync),
    .rise_o (trig_rise),
    .fall_o (trig_fall)
  );

  // Full-width product; only in-range distances reach the truncation to CW.
  assign prod = dist_q * CPC;
  always_comb begin
    echo_len = prod[CW-1:0];
    if (dist_q == '0 || 32'(dist_q) > max_range_in_centimeters)
      echo_len = CW'(NO_OBS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dist_q  <= '0;
      echo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dist_q  <= dist_d;
      echo_q  <= echo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dist_d  = dist_q;
    echo_d  = echo_q;
    case (state_q)
      IDLE: begin
        // Start at 1: the cycle that produced the rise is already a high cycle.
        if (trig_rise) begin
          state_d = TRIG_HI;
          cnt_d   = CW'(1);
        end
      end
      TRIG_HI: begin
        if (trig_fall) begin
          if (cnt_q >= CW'(TRIG_MIN)) begin
            dist_d  = bus.distance;
            cnt_d   = '0;
            state_d = BURST;
          end else begin
            state_d = IDLE;
          end
        end else if (trig_sync && cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BURST: begin
        if (cnt_q == CW'(BURST_T)) begin
          state_d = ECHO;
          echo_d  = 1'b1;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ECHO: begin
        if (cnt_q == echo_len) begin
          state_d = IDLE;
          echo_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.echo = echo_q;
  assign bus.busy = (state_q != IDLE);
endmodule
